// File: rtl/mvm_partial_accum.sv
// Partial-sum accumulator behind the stochastic MVM stage: sums N signed 4-lane partials, saturates, hands off via valid/ready.
// Optional build macro MVM_ACC_RELU_EN: clamp negative lane sums to zero before saturation.
module mvm_partial_accum #(
  parameter int LANES = 4,
  parameter int IN_W  = 4,
  parameter int CNT_W = 6,
  parameter int ACC_W = 10,
  parameter int OUT_W = 4
) (
  input  logic                   i_clk_acc,
  input  logic                   i_rst_acc,
  input  logic                   i_start_acc,
  input  logic [CNT_W-1:0]       i_num_terms,
  input  logic                   i_ismvm,
  input  logic [LANES*IN_W-1:0]  i_wx_result,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [LANES*OUT_W-1:0] o_acc_out,
  output logic                   o_sat,
  output logic                   o_busy
);

  // The accumulator must hold N full-scale partials without wrapping.
  if (ACC_W < IN_W + CNT_W) begin : g_acc_w_check
    $error("mvm_partial_accum: ACC_W must be >= IN_W + CNT_W");
  end

  localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN_I = -(1 << (OUT_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(SAT_MIN_I);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     ismvm_q;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [CNT_W-1:0]         term_cnt_q, term_cnt_d;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic [LANES*OUT_W-1:0]   acc_out_q, acc_out_d;
  logic                     sat_q, sat_d;
  logic                     valid_q, valid_d;

  logic                     strb_w;
  logic signed [ACC_W-1:0]  sum_w [LANES];
  logic [LANES*OUT_W-1:0]   clamped_w;
  logic                     sat_any_w;

  // A partial is presented in the first cycle the MVM busy flag is seen low.
  assign strb_w = ismvm_q & ~i_ismvm;

  // Per-lane next sum and its saturated view, consumed only on the final strobe.
  always_comb begin
    clamped_w = '0;
    sat_any_w = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      logic [IN_W-1:0] lane;
      lane     = i_wx_result[k*IN_W +: IN_W];
      sum_w[k] = acc_q[k] + {{(ACC_W-IN_W){lane[IN_W-1]}}, lane};
`ifdef MVM_ACC_RELU_EN
      if (sum_w[k][ACC_W-1]) begin
        clamped_w[k*OUT_W +: OUT_W] = '0;
      end else if (sum_w[k] > SAT_MAX) begin
        clamped_w[k*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        sat_any_w = 1'b1;
      end else begin
        clamped_w[k*OUT_W +: OUT_W] = sum_w[k][OUT_W-1:0];
      end
`else
      if (sum_w[k] > SAT_MAX) begin
        clamped_w[k*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        sat_any_w = 1'b1;
      end else if (sum_w[k] < SAT_MIN) begin
        clamped_w[k*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        sat_any_w = 1'b1;
      end else begin
        clamped_w[k*OUT_W +: OUT_W] = sum_w[k][OUT_W-1:0];
      end
`endif
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    term_cnt_d = term_cnt_q;
    acc_d      = acc_q;
    acc_out_d  = acc_out_q;
    sat_d      = sat_q;
    valid_d    = valid_q;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (i_start_acc) begin
          // Start wins over a coincident strobe: the new vector begins empty.
          state_d    = S_ACCUM;
          term_cnt_d = '0;
          n_d        = (i_num_terms == '0) ? CNT_W'(1) : i_num_terms;
          for (int k = 0; k < LANES; k++) acc_d[k] = '0;
        end else if (state_q == S_ACCUM && strb_w) begin
          acc_d      = sum_w;
          term_cnt_d = term_cnt_q + CNT_W'(1);
          if (term_cnt_q == n_q - CNT_W'(1)) begin
            state_d   = S_OUT;
            acc_out_d = clamped_w;
            sat_d     = sat_any_w;
            valid_d   = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (i_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the lane accumulators are a handful of flops, not a RAM, so they are reset like any register.
  always_ff @(posedge i_clk_acc) begin
    if (i_rst_acc) begin
      state_q    <= S_IDLE;
      ismvm_q    <= 1'b0;
      n_q        <= '0;
      term_cnt_q <= '0;
      acc_out_q  <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      ismvm_q    <= i_ismvm;
      n_q        <= n_d;
      term_cnt_q <= term_cnt_d;
      acc_out_q  <= acc_out_d;
      sat_q      <= sat_d;
      valid_q    <= valid_d;
      for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign o_valid   = valid_q;
  assign o_acc_out = acc_out_q;
  assign o_sat     = sat_q;
  assign o_busy    = (state_q != S_IDLE);

endmodule
